// File: rtl/oneapi_gasket_pkg.sv
// Shared types and index helpers for the AXI4-S to Avalon-ST pixel gasket.
//   gasket_state_e : ingress FSM states (SYNC waits for first SOF, RUN forwards)
//   beat_marks_t   : per-beat packet markers carried alongside pixel data
//   lower_bit_av/axi : LSB position of channel c of pixel p in each bus format
package oneapi_gasket_pkg;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } gasket_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_marks_t;

  function automatic int unsigned lower_bit_av(input int unsigned p,
                                               input int unsigned c,
                                               input int unsigned bits_per_pixel_av,
                                               input int unsigned bits_per_channel_av);
    return p * bits_per_pixel_av + c * bits_per_channel_av;
  endfunction

  function automatic int unsigned lower_bit_axi(input int unsigned p,
                                                input int unsigned c,
                                                input int unsigned bits_per_pixel_axi,
                                                input int unsigned bits_per_channel_axi);
    return p * bits_per_pixel_axi + c * bits_per_channel_axi;
  endfunction

endpackage

// File: rtl/oneapi_gasket_skid_buffer.sv
// Two-entry registered ready/valid slice. Output register O feeds the sink;
// skid register S catches the one beat that arrives while O is stalled.
// in_ready is a flop (!S.valid), so there is no combinational path from
// out_ready back to in_ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
module oneapi_gasket_skid_buffer #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             ready_q, ready_d;
  logic             accept_c;
  logic             o_adv_c;

  // Next-state: O drains S first so order is preserved; S only fills when O is stuck.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    accept_c  = in_valid & ready_q;
    o_adv_c   = !o_valid_q | out_ready;
    if (o_adv_c) begin
      if (s_valid_q) begin
        o_valid_d = 1'b1;
        o_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else begin
        o_valid_d = accept_c;
        if (accept_c) begin
          o_data_d = in_data;
        end
      end
    end else if (accept_c) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
    ready_d = !s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      ready_q   <= 1'b1;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = o_valid_q;
  assign out_data  = o_data_q;

endmodule

// File: rtl/oneapi_axs_to_avs_pixel_gasket.sv
// Ingress adapter: Intel Streaming Video AXI4-S pixels -> oneAPI Avalon-ST sink.
// Remaps each channel into its padded Avalon lane, maps tuser[0]/tlast to
// sop/eop, drops beats until the first SOF after reset, and registers the
// output through a two-entry skid buffer.
//   csi_clk, rsi_reset_n : clock, synchronous active-low reset
//   axs_*                : AXI4-S video sink (tready registered)
//   aso_*                : Avalon-ST source, readyLatency 0
//   coe_synced           : high once the first SOF has been accepted
module oneapi_axs_to_avs_pixel_gasket
  import oneapi_gasket_pkg::*;
#(
  parameter int unsigned PARALLEL_PIXELS      = 1,
  parameter int unsigned BITS_PER_CHANNEL     = 8,
  parameter int unsigned CHANNELS             = 3,
  parameter int unsigned BITS_PER_CHANNEL_AV  = 8,
  parameter int unsigned BITS_PER_PIXEL_AV    = 24,
  parameter int unsigned BITS_AV              = 24,
  parameter int unsigned EMPTY_BITS           = 2,
  parameter int unsigned BITS_PER_CHANNEL_AXI = 8,
  parameter int unsigned BITS_PER_PIXEL_AXI   = 24,
  parameter int unsigned BITS_AXI             = 24,
  parameter int unsigned TUSER_BITS           = 3
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset_n,
  output logic                  axs_tready,
  input  logic                  axs_tvalid,
  input  logic [BITS_AXI-1:0]   axs_tdata,
  input  logic                  axs_tlast,
  input  logic [TUSER_BITS-1:0] axs_tuser,
  input  logic                  aso_ready,
  output logic                  aso_valid,
  output logic [BITS_AV-1:0]    aso_data,
  output logic                  aso_startofpacket,
  output logic                  aso_endofpacket,
  output logic [EMPTY_BITS-1:0] aso_empty,
  output logic                  coe_synced
);

  typedef struct packed {
    logic [BITS_AV-1:0] data;
    beat_marks_t        marks;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  gasket_state_e      state_q, state_d;
  logic               synced_q;
  logic [BITS_AV-1:0] remap_c;
  beat_t              in_beat_c;
  beat_t              out_beat;
  logic               fwd_c;
  logic               unused_ok;

  // AXI pad bits and upper tuser bits are intentionally ignored.
  assign unused_ok = ^{axs_tdata, axs_tuser};

  // Channel remap; everything not written stays 0, which zeroes all Avalon pad bits.
  always_comb begin
    remap_c = '0;
    for (int unsigned p = 0; p < PARALLEL_PIXELS; p++) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        remap_c[lower_bit_av(p, c, BITS_PER_PIXEL_AV, BITS_PER_CHANNEL_AV) +: BITS_PER_CHANNEL_AXI] =
          axs_tdata[lower_bit_axi(p, c, BITS_PER_PIXEL_AXI, BITS_PER_CHANNEL_AXI) +: BITS_PER_CHANNEL_AXI];
      end
    end
  end

  always_comb begin
    in_beat_c.data      = remap_c;
    in_beat_c.marks.sop = axs_tuser[0];
    in_beat_c.marks.eop = axs_tlast;
  end

  // In SYNC only the SOF beat enters the buffer; other accepted beats are dropped.
  assign fwd_c = axs_tvalid & ((state_q == RUN) | axs_tuser[0]);

  // FSM next state: leave SYNC on the accepted SOF beat, then stay in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (axs_tvalid && axs_tready && axs_tuser[0]) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q  <= SYNC;
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      synced_q <= (state_d == RUN);
    end
  end

  oneapi_gasket_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk       (csi_clk),
    .rst_n     (rsi_reset_n),
    .in_valid  (fwd_c),
    .in_ready  (axs_tready),
    .in_data   (in_beat_c),
    .out_valid (aso_valid),
    .out_ready (aso_ready),
    .out_data  (out_beat)
  );

  assign aso_data          = out_beat.data;
  assign aso_startofpacket = out_beat.marks.sop;
  assign aso_endofpacket   = out_beat.marks.eop;
  assign aso_empty         = '0;
  assign coe_synced        = synced_q;

endmodule

// File: tb/tb_oneapi_axs_to_avs_pixel_gasket.sv
// Bench for oneapi_axs_to_avs_pixel_gasket: queue model of in-flight beats,
// per-cycle compare on the falling edge, directed literal checks.
module tb_oneapi_axs_to_avs_pixel_gasket;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axs_tready;
  logic        axs_tvalid = 1'b0;
  logic [23:0] axs_tdata = '0;
  logic        axs_tlast = 1'b0;
  logic [2:0]  axs_tuser = '0;
  logic        aso_ready = 1'b1;
  logic        aso_valid;
  logic [23:0] aso_data;
  logic        aso_sop;
  logic        aso_eop;
  logic [1:0]  aso_empty;
  logic        coe_synced;

  // Second instance in a wide configuration: 2 pixels, 10-bit AXI channels, 16-bit Avalon lanes.
  logic        w_tready;
  logic        w_tvalid = 1'b0;
  logic [63:0] w_tdata = '0;
  logic        w_tlast = 1'b0;
  logic [2:0]  w_tuser = '0;
  logic        w_valid;
  logic [95:0] w_data;
  logic        w_sop;
  logic        w_eop;
  logic [0:0]  w_empty;
  logic        w_synced;

  logic ordy_rand = 1'b0;
  logic ordy_fix  = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [23:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t q[$];
  logic m_synced = 1'b0;
  logic armed    = 1'b0;
  logic rst_prev = 1'b0;

  always #5 clk = ~clk;

  oneapi_axs_to_avs_pixel_gasket dut (
    .csi_clk           (clk),
    .rsi_reset_n       (rst_n),
    .axs_tready        (axs_tready),
    .axs_tvalid        (axs_tvalid),
    .axs_tdata         (axs_tdata),
    .axs_tlast         (axs_tlast),
    .axs_tuser         (axs_tuser),
    .aso_ready         (aso_ready),
    .aso_valid         (aso_valid),
    .aso_data          (aso_data),
    .aso_startofpacket (aso_sop),
    .aso_endofpacket   (aso_eop),
    .aso_empty         (aso_empty),
    .coe_synced        (coe_synced)
  );

  oneapi_axs_to_avs_pixel_gasket #(
    .PARALLEL_PIXELS      (2),
    .BITS_PER_CHANNEL     (10),
    .CHANNELS             (3),
    .BITS_PER_CHANNEL_AV  (16),
    .BITS_PER_PIXEL_AV    (48),
    .BITS_AV              (96),
    .EMPTY_BITS           (1),
    .BITS_PER_CHANNEL_AXI (10),
    .BITS_PER_PIXEL_AXI   (32),
    .BITS_AXI             (64),
    .TUSER_BITS           (3)
  ) dut_w (
    .csi_clk           (clk),
    .rsi_reset_n       (rst_n),
    .axs_tready        (w_tready),
    .axs_tvalid        (w_tvalid),
    .axs_tdata         (w_tdata),
    .axs_tlast         (w_tlast),
    .axs_tuser         (w_tuser),
    .aso_ready         (1'b1),
    .aso_valid         (w_valid),
    .aso_data          (w_data),
    .aso_startofpacket (w_sop),
    .aso_endofpacket   (w_eop),
    .aso_empty         (w_empty),
    .coe_synced        (w_synced)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink ready: either a fixed level or a fair coin per cycle, changed mid-cycle.
  always @(posedge clk) begin
    #2;
    aso_ready = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_fix;
  end

  // Model: the queue holds every beat accepted for forwarding and not yet
  // delivered. O is full iff the queue is non-empty; S is full iff it holds 2.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_prev) begin
        check("rst_valid", 128'(aso_valid), 128'(0));
        check("rst_sop", 128'(aso_sop), 128'(0));
        check("rst_eop", 128'(aso_eop), 128'(0));
        check("rst_data", 128'(aso_data), 128'(0));
        check("rst_empty", 128'(aso_empty), 128'(0));
        check("rst_tready", 128'(axs_tready), 128'(1));
        check("rst_synced", 128'(coe_synced), 128'(0));
      end else begin
        check("tready", 128'(axs_tready), 128'(q.size() < 2));
        check("valid", 128'(aso_valid), 128'(q.size() != 0));
        check("synced", 128'(coe_synced), 128'(m_synced));
        check("empty", 128'(aso_empty), 128'(0));
        if (aso_valid && q.size() != 0) begin
          check("data", 128'(aso_data), 128'(q[0].d));
          check("sop", 128'(aso_sop), 128'(q[0].sop));
          check("eop", 128'(aso_eop), 128'(q[0].eop));
        end
      end
    end
    rst_prev = !rst_n;
    if (!rst_n) begin
      q.delete();
      m_synced = 1'b0;
      armed    = 1'b1;
    end else if (armed) begin
      if (aso_valid && aso_ready && q.size() != 0) void'(q.pop_front());
      if (axs_tvalid && axs_tready && (m_synced || axs_tuser[0])) begin
        q.push_back({axs_tdata, axs_tuser[0], axs_tlast});
        m_synced = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the gasket takes it (bounded).
  task automatic send_beat(input logic [23:0] d, input logic last, input logic [2:0] user);
    int   n   = 0;
    logic acc = 1'b0;
    axs_tvalid = 1'b1;
    axs_tdata  = d;
    axs_tlast  = last;
    axs_tuser  = user;
    while (!acc) begin
      @(negedge clk);
      acc = axs_tready;
      step();
      n++;
      if (!acc && n > 1000) begin
        check("send_timeout", 128'(0), 128'(1));
        break;
      end
    end
    axs_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ordy_rand = 1'b0;
    ordy_fix  = 1'b1;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    check("drain", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Wide instance: pad bits set on the AXI side must not leak; lanes zero-extended.
    w_tvalid = 1'b1;
    w_tuser  = 3'b001;
    w_tdata  = 64'hEAA557FF_EAA557FF;
    w_tlast  = 1'b0;
    @(negedge clk);
    check("w_tready", 128'(w_tready), 128'(1));
    step();
    w_tuser = 3'b000;
    w_tdata = 64'hFFFFFFFF_FFFFFFFF;
    w_tlast = 1'b1;
    @(negedge clk);
    check("w_data0", 128'(w_data), 128'(96'h02AA_0155_03FF_02AA_0155_03FF));
    check("w_sop0", 128'(w_sop), 128'(1));
    check("w_synced", 128'(w_synced), 128'(1));
    step();
    w_tvalid = 1'b0;
    @(negedge clk);
    check("w_data1", 128'(w_data), 128'(96'h03FF_03FF_03FF_03FF_03FF_03FF));
    check("w_eop1", 128'(w_eop), 128'(1));
    check("w_empty", 128'(w_empty), 128'(0));
    step();

    // Sync: three non-SOF beats dropped (one with only upper tuser bits), then SOF.
    send_beat(24'hAAAAAA, 1'b0, 3'b000);
    send_beat(24'hBBBBBB, 1'b1, 3'b110);
    send_beat(24'hCCCCCC, 1'b0, 3'b000);
    @(negedge clk);
    check("sync_drop_valid", 128'(aso_valid), 128'(0));
    check("sync_drop_synced", 128'(coe_synced), 128'(0));
    check("sync_drop_tready", 128'(axs_tready), 128'(1));
    step();
    send_beat(24'h112233, 1'b0, 3'b001);
    @(negedge clk);
    check("sof_valid", 128'(aso_valid), 128'(1));
    check("sof_data", 128'(aso_data), 128'(24'h112233));
    check("sof_sop", 128'(aso_sop), 128'(1));
    check("sof_synced", 128'(coe_synced), 128'(1));
    step();

    // Full 1920-pixel line at one beat per cycle.
    t0 = $time;
    for (int i = 0; i < 1920; i++) begin
      send_beat(24'(i * 7 + 3), 1'(i == 1919), 3'(i == 0));
    end
    check("line_cycles", 128'(($time - t0) / 10), 128'(1920));
    step();

    // Streaming burst with the sink stalled for five cycles.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send_beat(24'h500000 + 24'(i), 1'(i == 19), 3'(i == 0));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        ordy_fix = 1'b0;
        @(negedge clk);
        check("stall_c1_tready", 128'(axs_tready), 128'(1));
        @(negedge clk);
        check("stall_c2_tready", 128'(axs_tready), 128'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        ordy_fix = 1'b1;
      end
    join
    drain();

    // Random valid/ready traffic.
    ordy_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1) step();
      send_beat(24'($urandom), 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 15) == 0));
    end
    drain();

    // Reset while the skid register holds a beat.
    ordy_fix = 1'b0;
    send_beat(24'h0A0A0A, 1'b0, 3'b000);
    send_beat(24'h0B0B0B, 1'b0, 3'b000);
    @(negedge clk);
    check("pre_rst_tready", 128'(axs_tready), 128'(0));
    step();
    rst_n      = 1'b0;
    axs_tvalid = 1'b1;
    axs_tdata  = 24'h0C0C0C;
    step();
    rst_n      = 1'b1;
    axs_tvalid = 1'b0;
    ordy_fix   = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 128'(aso_valid), 128'(0));
    check("mid_rst_data", 128'(aso_data), 128'(0));
    check("mid_rst_tready", 128'(axs_tready), 128'(1));
    check("mid_rst_synced", 128'(coe_synced), 128'(0));
    step();

    // After reset: rest of the line is dropped until the next SOF.
    send_beat(24'h0D0D0D, 1'b0, 3'b000);
    send_beat(24'h0E0E0E, 1'b1, 3'b000);
    @(negedge clk);
    check("resync_drop_valid", 128'(aso_valid), 128'(0));
    step();
    send_beat(24'hABCDEF, 1'b1, 3'b001);
    @(negedge clk);
    check("resync_data", 128'(aso_data), 128'(24'hABCDEF));
    check("resync_sop", 128'(aso_sop), 128'(1));
    check("resync_eop", 128'(aso_eop), 128'(1));
    check("resync_synced", 128'(coe_synced), 128'(1));
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
